prio_sel_buf: RTL and testbench
===============================

# prio_sel_buf

Parametrised, buffered successor to the single-register if/else priority selector. It takes `NCH` request channels of `WIDTH` data bits each and grants one per cycle, channel 0 highest by default. The granted word and its 1-based channel code are stored in a 2-entry output buffer with a valid/ready handshake. It sits between several producer blocks and one shared downstream consumer, and holds full throughput under backpressure.

## Interface
Parameters:
- `NCH`, default 3: number of request channels, ≥2.
- `WIDTH`, default 8: data width per channel.
- `CW`, default `$clog2(NCH+1)`: width of the channel code.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_vld`  in  NCH: per-channel request valid.
- `req_data`  in  NCH*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `req_rdy`  out  NCH: one-hot grant; channel k is accepted when `req_vld[k] && req_rdy[k]`.
- `out_vld`  out  1: head entry valid.
- `out_rdy`  in  1: consumer accepts the head entry.
- `out_data`  out  WIDTH: head data.
- `out_code`  out  CW: head channel code, k+1; 0 when empty.

## Operation
- Buffer FSM states:
  - `EMPTY`: 0 entries.
  - `ONE`: 1 entry.
  - `TWO`: 2 entries.
- Push = any request accepted; pop = `out_vld && out_rdy`.
- Transitions:
  - `EMPTY` goes to `ONE` on push.
  - `ONE` goes to `TWO` on push without pop, to `EMPTY` on pop without push, and stays `ONE` on push with pop (head replaced by the new word).
  - `TWO` goes to `ONE` on pop. No push is possible in `TWO`.
- Grant:
  - `req_rdy` is zero in `TWO` and zero when `req_vld == 0`.
  - Otherwise `req_rdy` is exactly one bit: the selected valid channel.
  - `req_rdy` depends only on `req_vld`, the FSM state and the RR pointer. It never depends combinationally on `out_rdy`.
- Ordering: entries leave in acceptance order. Entry 1 moves to the head on pop from `TWO`.
- Code arithmetic: `out_code` = granted index + 1, zero-extended to `CW`. With `NCH=3`: codes 1..3, 0 = empty.
- `out_data` and `out_code` hold stable while `out_vld && !out_rdy`.
- Reset values:
  - state `EMPTY`
  - `out_vld`=0, `out_data`=0, `out_code`=0
  - RR pointer 0
  - `req_rdy`=0
- Reset mid-operation: buffered entries are discarded immediately, and `out_vld` falls asynchronously with `rst_n`.

## Timing
- Latency: a request accepted at edge N appears on `out_*` after edge N when the buffer was `EMPTY`. It appears later only behind queued entries.
- Throughput: one word per cycle while `out_rdy`=1 and any `req_vld` is high.
- After a pop from `TWO`, `req_rdy` reasserts in the next cycle, not the same cycle.
- `req_vld` may drop without acceptance. No request is latched internally.

## Configuration
- `PRIO_SEL_BUF_RR_EN` defined:
  - Round-robin arbitration over an internal pointer P.
  - Search starts at channel P and wraps modulo `NCH`.
  - On each push, P becomes (granted index + 1) mod `NCH`. Wrap-around at `NCH-1` returns P to 0.
- `PRIO_SEL_BUF_RR_EN` not defined:
  - Fixed priority: lowest valid index wins.
  - No pointer register exists.

## Structure
- Package `prio_sel_pkg`:
  - buffer state enum (`EMPTY`/`ONE`/`TWO`)
  - code-width helper function
  - code constant `CODE_NONE` = 0
- One sub-module, `prio_sel_arb`: combinational one-hot grant from `req_vld`, an enable and the start pointer. With the macro off, the start pointer is tied to 0.
- Top level: FSM, 2-entry storage, head mux, pointer register.

## Test plan
All scenarios use `NCH=3`, `WIDTH=8`.
1. Reset: hold `rst_n`=0 with `req_vld`=3'b111 → `out_vld`=0, `out_code`=0, `out_data`=0x00. First grant occurs after release.
2. Priority: `req_vld`=3'b110, ch1=0x22, ch2=0x33, `out_rdy`=1, held → outputs (0x22, code 2), then (0x22, 2) repeatedly with the macro off. With the macro on: (0x22, 2), (0x33, 3), alternating.
3. Backpressure: `out_rdy`=0, single requests 0x11@ch0, 0x22@ch1, 0x33@ch2 → first two accepted and `req_rdy`=0 for 0x33. Then `out_rdy`=1 → out 0x11, 0x22, then 0x33 accepted and output with code 3.
4. Simultaneous push/pop in `ONE`: stream 0x01..0x08 on ch0 with `out_rdy`=1 → state stays `ONE`, one word per cycle, order 0x01..0x08.
5. Round robin, macro on: `req_vld`=3'b111, `out_rdy`=1 → codes 1,2,3,1,2,3. Macro off → 1,1,1,1.
6. Mid-operation reset: reach `TWO`, pulse `rst_n` low between edges → `out_vld` drops at once. After release `out_code`=0 and no stale data appears.

Source files
------------

// File: rtl/prio_sel_pkg.sv
// Shared types and helpers for the buffered priority selector.
package prio_sel_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  localparam int CODE_NONE = 0;

  function automatic int code_w(input int nch);
    return $clog2(nch + 1);
  endfunction

endpackage

// File: rtl/prio_sel_arb.sv
// Combinational one-hot arbiter: lowest valid channel at or after start wins,
// wrapping modulo NCH. With start tied to 0 this is fixed priority.
module prio_sel_arb #(
  parameter int NCH = 3,
  parameter int PW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic           en,
  input  logic [PW-1:0]  start,
  output logic [NCH-1:0] gnt
);

  logic [2*NCH-1:0] req_dbl;
  logic [NCH-1:0]   rot_req;
  logic [NCH-1:0]   rot_gnt;
  logic [2*NCH-1:0] gnt_dbl;

  // Rotate so that channel 'start' sits at bit 0, pick lowest, rotate back.
  assign req_dbl = {req, req} >> start;
  assign rot_req = req_dbl[NCH-1:0];

  always_comb begin
    rot_gnt = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        rot_gnt    = '0;
        rot_gnt[i] = 1'b1;
      end
    end
  end

  assign gnt_dbl = {{NCH{1'b0}}, rot_gnt} << start;
  assign gnt     = en ? (gnt_dbl[NCH-1:0] | gnt_dbl[2*NCH-1:NCH]) : '0;

endmodule

// File: rtl/prio_sel_buf.sv
// Priority selector feeding a 2-entry valid/ready output buffer.
// Define PRIO_SEL_BUF_RR_EN for round-robin arbitration; default is fixed priority.
module prio_sel_buf
  import prio_sel_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int WIDTH = 8,
  parameter int CW    = code_w(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       req_vld,
  input  logic [NCH*WIDTH-1:0] req_data,
  output logic [NCH-1:0]       req_rdy,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [WIDTH-1:0]     out_data,
  output logic [CW-1:0]        out_code
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  buf_state_t       state, state_nxt;
  logic [NCH-1:0]   gnt;
  logic             arb_en;
  logic             push;
  logic             pop;
  logic [PW-1:0]    ptr;
  logic [WIDTH-1:0] new_data, head_data, tail_data;
  logic [CW-1:0]    new_code, head_code, tail_code;

  prio_sel_arb #(
    .NCH (NCH),
    .PW  (PW)
  ) u_arb (
    .req   (req_vld),
    .en    (arb_en),
    .start (ptr),
    .gnt   (gnt)
  );

  assign req_rdy = gnt;
  assign push    = |gnt;
  assign pop     = out_vld & out_rdy;

  always_comb begin
    new_data = '0;
    new_code = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt[k]) begin
        new_data = req_data[k*WIDTH +: WIDTH];
        new_code = CW'(k + 1);
      end
    end
  end

`ifdef PRIO_SEL_BUF_RR_EN
  logic [PW-1:0] gidx;

  always_comb begin
    gidx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt[k]) gidx = PW'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (push) begin
      ptr <= (gidx == PW'(NCH - 1)) ? '0 : gidx + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = TWO;
        else if (!push && pop) state_nxt = EMPTY;
      end
      TWO:   if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Grant is held off during reset and whenever both entries are occupied.
  always_comb begin
    arb_en  = rst_n && (state != TWO);
    out_vld = (state != EMPTY);
  end

  // Entry storage: contents are only meaningful while the FSM says so.
  always_ff @(posedge clk) begin
    unique case (state)
      EMPTY: begin
        if (push) begin
          head_data <= new_data;
          head_code <= new_code;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_data <= new_data;
          head_code <= new_code;
        end else if (push) begin
          tail_data <= new_data;
          tail_code <= new_code;
        end
      end
      TWO: begin
        if (pop) begin
          head_data <= tail_data;
          head_code <= tail_code;
        end
      end
      default: ;
    endcase
  end

  assign out_data = out_vld ? head_data : '0;
  assign out_code = out_vld ? head_code : CW'(CODE_NONE);

endmodule

// File: tb/tb_prio_sel_buf.sv
// Directed self-checking bench for prio_sel_buf (NCH=3, WIDTH=8).
module tb_prio_sel_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_vld;
  logic [23:0] req_data;
  logic [2:0]  req_rdy;
  logic        out_vld;
  logic        out_rdy;
  logic [7:0]  out_data;
  logic [1:0]  out_code;
  logic [7:0]  d [3];

  int n_tests = 0;
  int n_fail  = 0;

  assign req_data = {d[2], d[1], d[0]};

  always #5 clk = ~clk;

  prio_sel_buf #(.NCH(3), .WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (req_vld),
    .req_data (req_data),
    .req_rdy  (req_rdy),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_code (out_code)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    req_vld = 3'b000;
    out_rdy = 1'b0;
    rst_n   = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    req_vld = 3'b111;
    out_rdy = 1'b0;
    d[0] = 8'hA0; d[1] = 8'hA1; d[2] = 8'hA2;
    tick(); tick();
    n_tests++;
    if (out_vld !== 1'b0 || out_code !== 2'd0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_out: vld=%b code=%0d data=%h want 0/0/00", out_vld, out_code, out_data);
    end
    n_tests++;
    if (req_rdy !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_rdy: got %b want 000", req_rdy);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (req_rdy !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %b want 001", req_rdy);
    end
    tick();
    n_tests++;
    if (out_vld !== 1'b1 || out_code !== 2'd1 || out_data !== 8'hA0) begin
      n_fail++;
      $display("FAIL reset_first_out: vld=%b code=%0d data=%h want 1/1/a0", out_vld, out_code, out_data);
    end
  endtask

  task automatic test_priority();
    logic [1:0] exp_code [4];
`ifdef PRIO_SEL_BUF_RR_EN
    exp_code = '{2'd2, 2'd3, 2'd2, 2'd3};
`else
    exp_code = '{2'd2, 2'd2, 2'd2, 2'd2};
`endif
    pulse_reset();
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    req_vld = 3'b110;
    out_rdy = 1'b1;
    #1;
    n_tests++;
    if (req_rdy !== 3'b010) begin
      n_fail++;
      $display("FAIL prio_grant: got %b want 010", req_rdy);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (out_vld !== 1'b1 || out_code !== exp_code[i] ||
          out_data !== ((exp_code[i] == 2'd2) ? 8'h22 : 8'h33)) begin
        n_fail++;
        $display("FAIL prio_out[%0d]: vld=%b code=%0d data=%h want code %0d", i, out_vld, out_code, out_data, exp_code[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    pulse_reset();
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    out_rdy = 1'b0;
    req_vld = 3'b001;
    #1;
    n_tests++;
    if (req_rdy !== 3'b001) begin
      n_fail++;
      $display("FAIL bp_grant0: got %b want 001", req_rdy);
    end
    tick();
    req_vld = 3'b010;
    #1;
    n_tests++;
    if (req_rdy !== 3'b010) begin
      n_fail++;
      $display("FAIL bp_grant1: got %b want 010", req_rdy);
    end
    tick();
    req_vld = 3'b100;
    #1;
    n_tests++;
    if (req_rdy !== 3'b000) begin
      n_fail++;
      $display("FAIL bp_full_rdy: got %b want 000", req_rdy);
    end
    tick();
    n_tests++;
    if (out_vld !== 1'b1 || out_data !== 8'h11 || out_code !== 2'd1) begin
      n_fail++;
      $display("FAIL bp_hold: vld=%b data=%h code=%0d want 1/11/1", out_vld, out_data, out_code);
    end
    out_rdy = 1'b1;
    #1;
    n_tests++;
    if (req_rdy !== 3'b000) begin
      n_fail++;
      $display("FAIL bp_rdy_same_cycle: got %b want 000", req_rdy);
    end
    tick();
    n_tests++;
    if (out_data !== 8'h22 || out_code !== 2'd2 || req_rdy !== 3'b100) begin
      n_fail++;
      $display("FAIL bp_second: data=%h code=%0d rdy=%b want 22/2/100", out_data, out_code, req_rdy);
    end
    tick();
    n_tests++;
    if (out_vld !== 1'b1 || out_data !== 8'h33 || out_code !== 2'd3) begin
      n_fail++;
      $display("FAIL bp_third: vld=%b data=%h code=%0d want 1/33/3", out_vld, out_data, out_code);
    end
    req_vld = 3'b000;
    tick();
    n_tests++;
    if (out_vld !== 1'b0 || out_code !== 2'd0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL bp_drain: vld=%b code=%0d data=%h want 0/0/00", out_vld, out_code, out_data);
    end
  endtask

  task automatic test_stream();
    pulse_reset();
    out_rdy = 1'b1;
    d[1] = 8'h00; d[2] = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      d[0]    = 8'(i);
      req_vld = 3'b001;
      #1;
      n_tests++;
      if (req_rdy !== 3'b001) begin
        n_fail++;
        $display("FAIL stream_rdy[%0d]: got %b want 001", i, req_rdy);
      end
      tick();
      n_tests++;
      if (out_vld !== 1'b1 || out_data !== 8'(i) || out_code !== 2'd1) begin
        n_fail++;
        $display("FAIL stream_out[%0d]: vld=%b data=%h code=%0d want 1/%h/1", i, out_vld, out_data, out_code, 8'(i));
      end
    end
    req_vld = 3'b000;
    tick();
    n_tests++;
    if (out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_empty: vld=%b want 0", out_vld);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_code [6];
`ifdef PRIO_SEL_BUF_RR_EN
    exp_code = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
`else
    exp_code = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
`endif
    pulse_reset();
    d[0] = 8'hA0; d[1] = 8'hA1; d[2] = 8'hA2;
    req_vld = 3'b111;
    out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (out_code !== exp_code[i] || out_data !== (8'h9F + 8'(exp_code[i]))) begin
        n_fail++;
        $display("FAIL rr_out[%0d]: code=%0d data=%h want code %0d", i, out_code, out_data, exp_code[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    pulse_reset();
    d[0] = 8'h5A; d[1] = 8'h6B; d[2] = 8'h00;
    out_rdy = 1'b0;
    req_vld = 3'b001;
    tick();
    req_vld = 3'b010;
    tick();
    req_vld = 3'b000;
    #1;
    n_tests++;
    if (out_vld !== 1'b1 || out_code !== 2'd1 || req_rdy !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_full: vld=%b code=%0d rdy=%b want 1/1/000", out_vld, out_code, req_rdy);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_vld !== 1'b0 || out_code !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_async_drop: vld=%b code=%0d want 0/0", out_vld, out_code);
    end
    #1;
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    tick();
    n_tests++;
    if (out_vld !== 1'b0 || out_code !== 2'd0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_no_stale: vld=%b code=%0d data=%h want 0/0/00", out_vld, out_code, out_data);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    req_vld = 3'b000;
    out_rdy = 1'b0;
    d[0] = 8'h00; d[1] = 8'h00; d[2] = 8'h00;
    test_reset();
    test_priority();
    test_backpressure();
    test_stream();
    test_round_robin();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
